// File: rtl/rr_burst_mux.sv
// Burst forwarder behind the 4-way round-robin arbiter: locks onto the granted
// requester for up to BURST_LEN beats and drives a single valid/ready output.
module rr_burst_mux #(
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          grant,
  input  logic [3:0]          req,
  input  logic [4*DATA_W-1:0] data_in,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_data,
  output logic [1:0]          out_src,
  output logic                out_last,
  output logic                busy,
  output logic [3:0]          done,
  output logic                grant_err
);

  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t              r_state;
  logic [1:0]          r_owner;
  logic [CNT_W-1:0]    r_count;
  logic                r_valid;
  logic [DATA_W-1:0]   r_data;
  logic [1:0]          r_src;
  logic                r_last;
  logic [3:0]          r_done;
  logic                r_grantErr;

  logic                w_grantOneHot;
  logic                w_grantMulti;
  logic [1:0]          w_grantIdx;
  logic [DATA_W-1:0]   w_grantData;
  logic [DATA_W-1:0]   w_ownerData;
  logic [CNT_W-1:0]    w_nextCount;

  // The index encoder is only meaningful when the grant is one-hot.
  always_comb begin
    w_grantIdx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (grant[i]) w_grantIdx = 2'(i);
    end
  end

  assign w_grantOneHot = (grant != 4'b0) && ((grant & (grant - 4'd1)) == 4'b0);
  assign w_grantMulti  = (grant != 4'b0) && !w_grantOneHot;
  assign w_grantData   = data_in[int'(w_grantIdx)*DATA_W +: DATA_W];
  assign w_ownerData   = data_in[int'(r_owner)*DATA_W +: DATA_W];
  assign w_nextCount   = r_count + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_owner    <= 2'd0;
      r_count    <= '0;
      r_valid    <= 1'b0;
      r_data     <= '0;
      r_src      <= 2'd0;
      r_last     <= 1'b0;
      r_done     <= 4'b0;
      r_grantErr <= 1'b0;
    end else begin
      r_done     <= 4'b0;
      r_grantErr <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grantOneHot && req[w_grantIdx]) begin
            r_owner <= w_grantIdx;
            r_src   <= w_grantIdx;
            r_data  <= w_grantData;
            r_valid <= 1'b1;
            r_count <= '0;
            r_last  <= (BURST_LEN == 1);
            r_state <= XFER;
          end else if (w_grantMulti) begin
            r_grantErr <= 1'b1;
          end
        end
        XFER: begin
          // A presented beat stays put until accepted, whatever req does.
          if (r_valid && out_ready) begin
            if (r_count == LAST_CNT || !req[r_owner]) begin
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_done  <= 4'b0001 << r_owner;
              r_state <= DONE;
            end else begin
              r_count <= w_nextCount;
              r_data  <= w_ownerData;
              r_last  <= (w_nextCount == LAST_CNT);
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_src   = r_src;
  assign out_last  = r_last;
  assign busy      = (r_state != IDLE);
  assign done      = r_done;
  assign grant_err = r_grantErr;

endmodule

// File: tb/tb_rr_burst_mux.sv
// Randomized bench for rr_burst_mux, checked every cycle against a
// transaction-style reference model (owner / beats-sent bookkeeping).
module tb_rr_burst_mux;

  localparam int DATA_W    = 8;
  localparam int BURST_LEN = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  grant;
  logic [3:0]  req;
  logic [31:0] data_in;
  logic        out_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_src;
  logic        out_last;
  logic        busy;
  logic [3:0]  done;
  logic        grant_err;

  int compared = 0;
  int mismatched = 0;

  // Reference model: owner < 0 means nobody holds the channel.
  int         mOwner = -1;
  int         mBeat = 0;
  bit         mValid = 0;
  bit         mLast = 0;
  logic [7:0] mData = '0;
  logic [1:0] mSrc = '0;
  logic [3:0] mDone = '0;
  bit         mErr = 0;

  rr_burst_mux #(.DATA_W(DATA_W), .BURST_LEN(BURST_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .grant(grant), .req(req), .data_in(data_in),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_src(out_src), .out_last(out_last), .busy(busy), .done(done),
    .grant_err(grant_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, actual, expected);
    end
  endtask

  task automatic modelReset();
    mOwner = -1; mBeat = 0; mValid = 0; mLast = 0;
    mData = '0; mSrc = '0; mDone = '0; mErr = 0;
  endtask

  // Predicts the outputs after the coming rising edge from the current inputs.
  task automatic modelStep();
    bit wasDone;
    int k;
    wasDone = (mDone != 4'b0);
    mDone = '0;
    mErr = 0;
    if (wasDone) begin
      mOwner = -1;
    end else if (mOwner < 0) begin
      if ($countones(grant) == 1) begin
        k = 0;
        for (int i = 0; i < 4; i++) if (grant[i]) k = i;
        if (req[k]) begin
          mOwner = k; mBeat = 0; mValid = 1; mSrc = 2'(k);
          mData = data_in[k*8 +: 8];
          mLast = (BURST_LEN == 1);
        end
      end else if ($countones(grant) >= 2) begin
        mErr = 1;
      end
    end else if (out_ready) begin
      if (mBeat == BURST_LEN - 1 || !req[mOwner]) begin
        mValid = 0; mLast = 0;
        mDone = 4'b0001 << mOwner;
        mOwner = -1;
      end else begin
        mBeat++;
        mData = data_in[mOwner*8 +: 8];
        mLast = (mBeat == BURST_LEN - 1);
      end
    end
  endtask

  task automatic compareAll();
    bit expBusy;
    expBusy = (mOwner >= 0) || (mDone != 4'b0);
    checkOutput("out_valid", 32'(out_valid), 32'(mValid));
    checkOutput("out_last", 32'(out_last), 32'(mLast));
    checkOutput("busy", 32'(busy), 32'(expBusy));
    checkOutput("done", 32'(done), 32'(mDone));
    checkOutput("grant_err", 32'(grant_err), 32'(mErr));
    if (mValid) begin
      checkOutput("out_data", 32'(out_data), 32'(mData));
      checkOutput("out_src", 32'(out_src), 32'(mSrc));
    end
  endtask

  task automatic applyStimulus(input logic [3:0] g, input logic [3:0] r, input logic rdy, input logic [31:0] d);
    grant = g; req = r; out_ready = rdy; data_in = d;
  endtask

  // One clock: drive, predict, let the edge happen, compare on the falling edge.
  task automatic runCycle(input logic [3:0] g, input logic [3:0] r, input logic rdy, input logic [31:0] d);
    applyStimulus(g, r, rdy, d);
    modelStep();
    @(posedge clk);
    @(negedge clk);
    compareAll();
  endtask

  // Asserts reset mid-cycle, checks outputs clear at once, releases on a falling edge.
  task automatic doReset();
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    compareAll();
    checkOutput("rst_out_data", 32'(out_data), 32'h0);
    checkOutput("rst_out_src", 32'(out_src), 32'h0);
    @(negedge clk);
    compareAll();
    rst_n = 1'b1;
  endtask

  function automatic logic [3:0] randGrant();
    logic [3:0] g;
    int sel;
    sel = $urandom_range(0, 9);
    if (sel == 6) g = 4'b0;
    else if (sel == 7) begin
      g = 4'($urandom);
      while ($countones(g) < 2) g = 4'($urandom);
    end else g = 4'b0001 << $urandom_range(0, 3);
    return g;
  endfunction

  initial begin
    logic [31:0] d;
    rst_n = 1'b0;
    applyStimulus(4'b0, 4'b0, 1'b0, 32'h0);
    @(negedge clk);
    doReset();

    // Full burst from requester 2 with A0..A3 on successive cycles.
    for (int i = 0; i < 7; i++) begin
      d = 32'h0;
      d[23:16] = 8'hA0 + 8'(i);
      runCycle(i == 0 ? 4'b0100 : 4'b0000, 4'b0100, 1'b1, d);
    end

    // Same burst with the sink stalling on the second and third cycles.
    for (int i = 0; i < 9; i++) begin
      d = 32'h0;
      d[23:16] = 8'hA0 + 8'(i);
      runCycle(i == 0 ? 4'b0100 : 4'b0000, 4'b0100, !(i == 2 || i == 3), d);
    end

    // Early release by requester 0 while the arbiter switches to requester 3.
    runCycle(4'b0001, 4'b0001, 1'b1, 32'h000000C0);
    runCycle(4'b1000, 4'b1001, 1'b1, 32'h000000C1);
    runCycle(4'b1000, 4'b1000, 1'b1, 32'h000000C2);
    runCycle(4'b0000, 4'b0000, 1'b1, 32'h0);
    runCycle(4'b0000, 4'b0000, 1'b1, 32'h0);

    // Malformed grant, then a legal one.
    runCycle(4'b0110, 4'b0110, 1'b1, 32'h0);
    runCycle(4'b0000, 4'b0000, 1'b1, 32'h0);
    for (int i = 0; i < 7; i++) runCycle(i == 0 ? 4'b0010 : 4'b0000, 4'b0010, 1'b1, $urandom);

    // Back-to-back owners 3 then 1 with every request high.
    for (int i = 0; i < 14; i++) runCycle(i < 6 ? 4'b1000 : 4'b0010, 4'b1111, 1'b1, $urandom);

    // Reset in the middle of an owner-1 burst.
    runCycle(4'b0010, 4'b0010, 1'b1, 32'h0000B000);
    runCycle(4'b0010, 4'b0010, 1'b1, 32'h0000B100);
    doReset();
    runCycle(4'b0010, 4'b0010, 1'b1, 32'h0000B200);
    for (int i = 0; i < 5; i++) runCycle(4'b0000, 4'b0010, 1'b1, $urandom);

    // Randomized traffic with occasional asynchronous resets.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) doReset();
      else runCycle(randGrant(), ~(4'($urandom) & 4'($urandom) & 4'($urandom)),
                    $urandom_range(0, 3) != 0, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/rr_burst_mux.md
# rr_burst_mux

Downstream consumer of the 4-requester round-robin arbiter. Takes the arbiter's one-hot `grant`, locks onto the granted requester for a bounded burst, and forwards that requester's data words onto a single shared output channel with a valid/ready handshake. Provides per-requester completion pulses and flags malformed grants.

## Interface
Parameters:
- DATA_W, 8, width of each requester data word and of the output word
- BURST_LEN, 4, maximum beats per ownership; legal range 1..16; counter width is clog2(BURST_LEN), minimum 1 bit

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- grant  input  4  one-hot grant from the arbiter; bit i selects requester i
- req  input  4  same request vector the arbiter sees; req[i] high means requester i has data
- data_in  input  4*DATA_W  requester i data in bits [i*DATA_W +: DATA_W]
- out_ready  input  1  sink accepts the current beat
- out_valid  output  1  registered; beat present on out_data
- out_data  output  DATA_W  registered beat data
- out_src  output  2  registered index of the current owner
- out_last  output  1  registered; high with the beat whose count equals BURST_LEN-1
- busy  output  1  high in XFER and DONE
- done  output  4  one-cycle pulse on bit owner when the burst ends
- grant_err  output  1  one-cycle pulse when a non-one-hot, non-zero grant is sampled in IDLE

## Operation
- States: IDLE, XFER, DONE.
- IDLE: sample `grant`.
  - If grant is exactly one-hot (bit k) and req[k]=1: latch owner=k, load out_data from slice k, set out_valid=1, out_src=k, count=0, set out_last if BURST_LEN=1, go to XFER.
  - If grant is one-hot but req[k]=0, or grant=0: stay in IDLE with no outputs.
  - If grant has two or more bits set: pulse grant_err and stay in IDLE.
- XFER: the owner is locked, and grant changes are ignored.
  - out_valid=1 and out_ready=0: hold out_data, out_valid and out_last stable. This holds even if req[owner] drops; a presented beat is never withdrawn.
  - Beat accepted (out_valid and out_ready):
    - If count==BURST_LEN-1 or req[owner]==0: clear out_valid and out_last, go to DONE.
    - Otherwise: count+1, load next word from slice owner, keep out_valid=1, and set out_last if the new count equals BURST_LEN-1.
- DONE: assert done[owner] for exactly one cycle with out_valid=0, then go to IDLE. grant is not sampled in DONE.
- The count never exceeds BURST_LEN-1, and a burst never spans a second owner.
- Reset (async assert at any time, including mid-burst):
  - state=IDLE, count=0, out_valid=0, out_data=0, out_src=0, out_last=0, busy=0, done=0, grant_err=0.
  - No done pulse is issued for an aborted burst.

## Timing
- Grant sampled at the rising edge ending cycle N (IDLE) gives the first beat on out_valid in cycle N+1.
- With out_ready held high and req[owner] high, beats occupy N+1..N+BURST_LEN, done pulses in N+BURST_LEN+1, and IDLE is in N+BURST_LEN+2.
- Minimum gap between bursts: 2 idle cycles on out_valid (DONE plus IDLE).
- Early end: if req[owner] is low at the edge where beat j is accepted, DONE follows in the next cycle.
- Each out_ready stall cycle extends the burst by exactly one cycle.
- grant and req are treated as combinational inputs stable before the edge, so no synchronisation is needed.
- Release rst_n synchronously to clk externally. The first sample is taken on the first edge after deassertion.

## Test plan
- Reset mid-burst: reset at beat 2 of owner 1 -> all outputs 0 on the same cycle, no done pulse, first IDLE sample on the first edge after release.
- Full burst, BURST_LEN=4, grant=4'b0100, req=4'b0100, out_ready=1, data_in slice 2 = 8'hA0..A3 on successive cycles:
  - 4 beats A0..A3 with out_src=2 and out_last on A3.
  - done=4'b0100 one cycle later, then busy=0.
- Backpressure: same as above with out_ready low on cycles 2 and 3 -> beat 2 data is held for 3 cycles, total burst length 6 cycles, no beat lost or duplicated.
- Early release: grant=4'b0001; req[0] drops after beat 2 is accepted -> exactly 2 beats, done=4'b0001, and grant switching to 4'b1000 during XFER has no effect on out_src=0.
- Bad grant: grant=4'b0110 in IDLE -> grant_err pulses for 1 cycle, out_valid stays 0, and the next legal grant is accepted normally.
- Back-to-back owners: grant 4'b1000 then 4'b0010 with all req high -> owner 3 burst, done[3], 1 IDLE cycle, then owner 1 burst with out_src=1.
